// File: rtl/nou_pkg.sv
// Shared NOU definitions: request-queue sizing, word and count types.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package nou_pkg;

    // Default request-queue geometry.
    localparam int XRQ_DATA_W       = 64;
    localparam int XRQ_DEPTH        = 16;
    localparam int XRQ_AFULL_MARGIN = 2;

    // Occupancy needs one more bit than a pointer so that DEPTH is representable.
    localparam int XRQ_PTR_W = $clog2(XRQ_DEPTH);
    localparam int XRQ_CNT_W = XRQ_PTR_W + 1;

    typedef logic [XRQ_DATA_W-1:0] xrq_word_t;
    typedef logic [XRQ_CNT_W-1:0]  xrq_cnt_t;

    // True when v is a positive power of two; used for elaboration checks.
    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/nou_xrq_mem.sv
// Request-queue storage: DEPTH x DATA_W, one synchronous write port, one async read port.
// Latency: write visible on the read port after the write edge; read is combinational.
// Backpressure: none; the caller only asserts we when the slot is free.
//
// Ports:
//   clk    in   write clock
//   we     in   write enable
//   waddr  in   write slot
//   wdata  in   write word
//   raddr  in   read slot
//   rdata  out  contents of mem[raddr]
//
// Plain flop array with no reset on the data; stale contents are never observed
// because the owning queue only exposes slots it has written since reset.
module nou_xrq_mem
    import nou_pkg::*;
#(
    parameter int DATA_W = XRQ_DATA_W,
    parameter int DEPTH  = XRQ_DEPTH
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/nou_xrq.sv
// NOU request queue: circular FWFT FIFO fed by the fetch controller's f1 strobe.
// Latency: word pushed at edge N is at the head after edge N; pop-to-next-head is 1 cycle.
// Backpressure: full/almost_full from registered count only; push while full is dropped
// and latches a sticky overflow error.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   data_vld_f1, data_f1 push strobe and word from the fetch controller
//   xrq_is_full          count == DEPTH
//   xrq_is_almost_full   count >= DEPTH-AFULL_MARGIN
//   xrq_vld, xrq_data    head entry (valid when count != 0)
//   xrq_rdy              consumer accepts the head this cycle
//   xrq_count            current occupancy
//   xrq_ovf_err          sticky: push seen while full
module nou_xrq
    import nou_pkg::*;
#(
    parameter int DATA_W       = XRQ_DATA_W,
    parameter int DEPTH        = XRQ_DEPTH,
    parameter int AFULL_MARGIN = XRQ_AFULL_MARGIN
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   data_vld_f1,
    input  logic [DATA_W-1:0]      data_f1,
    output logic                   xrq_is_full,
    output logic                   xrq_is_almost_full,
    output logic                   xrq_vld,
    output logic [DATA_W-1:0]      xrq_data,
    input  logic                   xrq_rdy,
    output logic [$clog2(DEPTH):0] xrq_count,
    output logic                   xrq_ovf_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(DEPTH - AFULL_MARGIN);

    // ------------------------------------------------------------------
    // Elaboration checks on the geometry.
    // ------------------------------------------------------------------
    if (!is_pow2(DEPTH) || DEPTH < 4) begin : g_bad_depth
        $error("nou_xrq: DEPTH must be a power of two and >= 4");
    end

    if (AFULL_MARGIN < 1 || AFULL_MARGIN > DEPTH - 1) begin : g_bad_margin
        $error("nou_xrq: AFULL_MARGIN must be in 1..DEPTH-1");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             ovf_err;

    logic push;
    logic pop;

    // Status comes from registered count only, so the fetch controller can use
    // full/almost_full in its combinational read enable without forming a loop.
    assign xrq_is_full        = (count == FULL_CNT);
    assign xrq_is_almost_full = (count >= AFULL_CNT);
    assign xrq_vld            = (count != '0);
    assign xrq_count          = count;
    assign xrq_ovf_err        = ovf_err;

    // A push while full is dropped even if the head pops in the same cycle: the
    // decision uses the pre-edge occupancy.
    assign push = data_vld_f1 & ~xrq_is_full;
    assign pop  = xrq_vld & xrq_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ovf_err <= 1'b0;
        end else begin
            // Pointers are exactly log2(DEPTH) bits, so they wrap for free.
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end

            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            if (data_vld_f1 && xrq_is_full) begin
                ovf_err <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Storage. The head is read asynchronously at rd_ptr, which gives
    // first-word-fall-through and keeps xrq_data stable while the head is held.
    // ------------------------------------------------------------------
    nou_xrq_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk    (clk),
        .we     (push),
        .waddr  (wr_ptr),
        .wdata  (data_f1),
        .raddr  (rd_ptr),
        .rdata  (xrq_data)
    );

endmodule

// File: tb/tb_nou_xrq.sv
// Self-checking bench for nou_xrq (DEPTH=16, AFULL_MARGIN=2, DATA_W=64).
// Latency: n/a.
// Backpressure: n/a.
module tb_nou_xrq;

    localparam int DW    = 64;
    localparam int DEPTH = 16;
    localparam int AFULL = 14;

    logic          clk = 1'b0;
    logic          rst;
    logic          data_vld_f1;
    logic [DW-1:0] data_f1;
    logic          xrq_is_full;
    logic          xrq_is_almost_full;
    logic          xrq_vld;
    logic [DW-1:0] xrq_data;
    logic          xrq_rdy;
    logic [4:0]    xrq_count;
    logic          xrq_ovf_err;

    always #5 clk = ~clk;

    nou_xrq dut (
        .clk                (clk),
        .rst                (rst),
        .data_vld_f1        (data_vld_f1),
        .data_f1            (data_f1),
        .xrq_is_full        (xrq_is_full),
        .xrq_is_almost_full (xrq_is_almost_full),
        .xrq_vld            (xrq_vld),
        .xrq_data           (xrq_data),
        .xrq_rdy            (xrq_rdy),
        .xrq_count          (xrq_count),
        .xrq_ovf_err        (xrq_ovf_err)
    );

    int n_chk = 0;
    int n_err = 0;

    // Scoreboard: words expected at the head, oldest first.
    logic [DW-1:0] sb[$];
    logic          ovf_m = 1'b0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        ovf_m = 1'b0;
    endtask

    // One clock cycle, entered and left just after a falling edge.
    // Pre-edge: head/valid checked against the scoreboard, model updated.
    // Post-edge: all status outputs checked against the model.
    task automatic cyc(input logic v, input logic [DW-1:0] d, input logic r);
        bit full_m;
        data_vld_f1 = v;
        data_f1     = d;
        xrq_rdy     = r;
        full_m      = (sb.size() == DEPTH);
        chk("pre_vld", xrq_vld, (sb.size() != 0));
        if (sb.size() != 0) begin
            chk("head_dat", xrq_data, sb[0]);
            if (r) void'(sb.pop_front());
        end
        if (v) begin
            if (full_m) ovf_m = 1'b1;
            else        sb.push_back(d);
        end
        @(posedge clk);
        @(negedge clk);
        chk("count", xrq_count, sb.size());
        chk("full", xrq_is_full, (sb.size() == DEPTH));
        chk("afull", xrq_is_almost_full, (sb.size() >= AFULL));
        chk("vld", xrq_vld, (sb.size() != 0));
        chk("ovf", xrq_ovf_err, ovf_m);
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            data_vld_f1 = 1'($urandom);
            xrq_rdy     = 1'($urandom);
            data_f1     = {$urandom, $urandom};
            @(posedge clk);
            @(negedge clk);
            chk("rst_vld", xrq_vld, 0);
            chk("rst_full", xrq_is_full, 0);
            chk("rst_afull", xrq_is_almost_full, 0);
            chk("rst_count", xrq_count, 0);
            chk("rst_ovf", xrq_ovf_err, 0);
        end
        rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic          v;
        logic [DW-1:0] d;
        logic          r;
        logic [4:0]    cnt;
        logic          vld;
        logic [DW-1:0] head;
    } vec_t;

    vec_t tbl[11];

    initial begin
        // Short hand-computed sequence from empty: push/pop mixes and empty corners.
        tbl[0]  = '{1'b1, 64'hA1, 1'b0, 5'd1, 1'b1, 64'hA1};
        tbl[1]  = '{1'b1, 64'hA2, 1'b1, 5'd1, 1'b1, 64'hA2};
        tbl[2]  = '{1'b0, 64'h0,  1'b1, 5'd0, 1'b0, 64'h0};
        tbl[3]  = '{1'b0, 64'h0,  1'b1, 5'd0, 1'b0, 64'h0};
        tbl[4]  = '{1'b1, 64'hA3, 1'b1, 5'd1, 1'b1, 64'hA3};
        tbl[5]  = '{1'b1, 64'hA4, 1'b0, 5'd2, 1'b1, 64'hA3};
        tbl[6]  = '{1'b1, 64'hA5, 1'b0, 5'd3, 1'b1, 64'hA3};
        tbl[7]  = '{1'b0, 64'h0,  1'b1, 5'd2, 1'b1, 64'hA4};
        tbl[8]  = '{1'b0, 64'h0,  1'b0, 5'd2, 1'b1, 64'hA4};
        tbl[9]  = '{1'b0, 64'h0,  1'b1, 5'd1, 1'b1, 64'hA5};
        tbl[10] = '{1'b0, 64'h0,  1'b1, 5'd0, 1'b0, 64'h0};

        rst = 1'b1;
        data_vld_f1 = 1'b0;
        data_f1 = '0;
        xrq_rdy = 1'b0;
        @(negedge clk);

        // 1. Reset with random inputs, then a push right after release lands.
        do_reset(3);
        cyc(1'b1, 64'h5A5A, 1'b0);
        chk("post_rst_head", xrq_data, 64'h5A5A);
        cyc(1'b0, 64'h0, 1'b1);

        // Table-driven sequence.
        for (int i = 0; i < 11; i++) begin
            cyc(tbl[i].v, tbl[i].d, tbl[i].r);
            chk("tbl_cnt", xrq_count, tbl[i].cnt);
            chk("tbl_vld", xrq_vld, tbl[i].vld);
            if (tbl[i].vld) chk("tbl_head", xrq_data, tbl[i].head);
        end

        // 2. Fill 0x1..0xE with no consumer.
        for (int i = 1; i <= 14; i++) begin
            cyc(1'b1, 64'(i), 1'b0);
            chk("fill_afull", xrq_is_almost_full, (i >= 14));
        end
        chk("fill_count", xrq_count, 14);
        chk("fill_full", xrq_is_full, 0);
        chk("fill_head", xrq_data, 64'h1);

        // 3. Overflow: reach full, then push 0xDEAD with a simultaneous pop.
        cyc(1'b1, 64'hF, 1'b0);
        cyc(1'b1, 64'h10, 1'b0);
        chk("ovf_full", xrq_is_full, 1);
        cyc(1'b1, 64'hDEAD, 1'b1);
        chk("ovf_err", xrq_ovf_err, 1);
        chk("ovf_count", xrq_count, 15);
        chk("ovf_head", xrq_data, 64'h2);
        for (int i = 0; i < 40 && sb.size() != 0; i++) cyc(1'b0, 64'h0, 1'b1);
        chk("ovf_drained", sb.size(), 0);
        chk("ovf_sticky", xrq_ovf_err, 1);

        // 4. Streaming from empty: occupancy holds at 1, pointers wrap.
        do_reset(1);
        for (int i = 0; i < 100; i++) begin
            cyc(1'b1, 64'h1000 + 64'(i), 1'b1);
            chk("stream_cnt", xrq_count, 1);
            chk("stream_head", xrq_data, 64'h1000 + 64'(i));
        end
        cyc(1'b0, 64'h0, 1'b1);

        // 5. Random back-pressure with a gated fetch-controller model.
        for (int i = 0; i < 10000; i++) begin
            logic v;
            v = ~xrq_is_full & ~xrq_is_almost_full & 1'($urandom);
            cyc(v, {$urandom, $urandom}, 1'($urandom));
            chk("bp_cnt_le15", (xrq_count <= 15), 1);
        end
        chk("bp_ovf", xrq_ovf_err, 0);
        for (int i = 0; i < 40 && sb.size() != 0; i++) cyc(1'b0, 64'h0, 1'b1);

        // 6. Reset in the middle of an active push+pop cycle.
        for (int i = 0; i < 9; i++) cyc(1'b1, 64'h300 + 64'(i), 1'b0);
        chk("mid_count", xrq_count, 9);
        data_vld_f1 = 1'b1;
        data_f1     = 64'hBAD;
        xrq_rdy     = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_count", xrq_count, 0);
        chk("mid_rst_vld", xrq_vld, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b1, 64'h77, 1'b0);
        chk("mid_new_head", xrq_data, 64'h77);
        chk("mid_new_count", xrq_count, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
